// File: rtl/fir_coef_loader.sv
// Coefficient bank, serial coefficient loader and sample streamer for a transposed FIR.
// Optional: define FIR_LOADER_DRAIN_EN to flush in-flight outputs (DRAIN state) before a reload.
module fir_coef_loader #(
  parameter int W1    = 9,
  parameter int L     = 4,
  parameter int AW    = 2,
  parameter int Mpipe = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W1-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          coef_ok,
  input  logic          s_valid,
  input  logic [W1-1:0] s_data,
  output logic          s_ready,
  output logic          Load_x,
  output logic [W1-1:0] x_out,
  output logic [W1-1:0] c_out,
  output logic          y_valid
);
  localparam int STAGES  = Mpipe + 2;
  localparam int CNT_MAX = (L > STAGES) ? L : STAGES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [L-1:0][W1-1:0] bank, bank_nxt;
  logic                 bank_we;
  logic [AW-1:0]        tap_nxt;
  logic                 load_go;
  logic                 vld_in;
  logic [STAGES:1]      vld_pipe;

  assign bank_we = wr_en && (state == IDLE || state == RUN) &&
                   ({1'b0, wr_addr} < (AW+1)'(L));

  // Loads read through the write port so a write in the start cycle is the value sent.
  for (genvar k = 0; k < L; k++) begin : g_tap
    assign bank_nxt[k] = (bank_we && wr_addr == AW'(k)) ? wr_data : bank[k];
  end

  assign tap_nxt = AW'(cnt) + AW'(1);

  // x passes straight through so the filter's own x register is the first valid stage.
  assign vld_in  = (state == RUN) && s_valid;
  assign x_out   = vld_in ? s_data : '0;
  assign y_valid = vld_pipe[STAGES];

  always_comb begin
    load_go = 1'b0;
    case (state)
      IDLE:  load_go = start;
`ifdef FIR_LOADER_DRAIN_EN
      DRAIN: load_go = (cnt == CW'(STAGES-1));
`else
      RUN:   load_go = start;
`endif
      default: load_go = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bank     <= '0;
      Load_x   <= 1'b1;
      c_out    <= '0;
      busy     <= 1'b0;
      coef_ok  <= 1'b0;
      s_ready  <= 1'b0;
      vld_pipe <= '0;
    end else begin
      bank     <= bank_nxt;
      vld_pipe <= {vld_pipe[STAGES-1:1], vld_in};
      if (load_go) begin
        state    <= LOAD;
        cnt      <= '0;
        Load_x   <= 1'b0;
        c_out    <= bank_nxt[0];
        busy     <= 1'b1;
        coef_ok  <= 1'b0;
        s_ready  <= 1'b0;
        vld_pipe <= '0;
      end else begin
        case (state)
          LOAD: begin
            if (cnt == CW'(L-1)) begin
              state   <= RUN;
              Load_x  <= 1'b1;
              c_out   <= '0;
              busy    <= 1'b0;
              coef_ok <= 1'b1;
              s_ready <= 1'b1;
            end else begin
              cnt   <= cnt + 1'b1;
              c_out <= bank_nxt[tap_nxt];
            end
          end
`ifdef FIR_LOADER_DRAIN_EN
          RUN: begin
            if (start) begin
              state   <= DRAIN;
              cnt     <= '0;
              busy    <= 1'b1;
              s_ready <= 1'b0;
            end
          end
          DRAIN: cnt <= cnt + 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with a small behavioural model of the fed filter.
module tb_fir_coef_loader;
  localparam int W1 = 9, L = 4, AW = 2, MPIPE = 3, STAGES = MPIPE + 2;

  logic          clk = 1'b0;
  logic          reset, wr_en, start, s_valid;
  logic [AW-1:0] wr_addr;
  logic [W1-1:0] wr_data, s_data;
  logic          busy, coef_ok, s_ready, load_x, y_valid;
  logic [W1-1:0] x_out, c_out;

  always #5 clk = ~clk;

  fir_coef_loader #(.W1(W1), .L(L), .AW(AW), .Mpipe(MPIPE)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .coef_ok(coef_ok), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .Load_x(load_x), .x_out(x_out), .c_out(c_out), .y_valid(y_valid)
  );

  // Filter: coefficients shift in at c[L-1]; y = c[L-1]*x[n] + ... + c[0]*x[n-L+1].
  int cf[L];
  int xr;
  int pm[MPIPE][L];
  int acc[L];
  always @(posedge clk) begin
    if (!load_x) begin
      for (int k = 0; k < L-1; k++) cf[k] <= cf[k+1];
      cf[L-1] <= int'($signed(c_out));
    end else begin
      xr <= int'($signed(x_out));
    end
    for (int k = 0; k < L; k++) begin
      pm[0][k] <= xr * cf[k];
      for (int j = 1; j < MPIPE; j++) pm[j][k] <= pm[j-1][k];
    end
    acc[L-1] <= pm[MPIPE-1][0];
    for (int k = 0; k < L-1; k++) acc[k] <= acc[k+1] + pm[MPIPE-1][L-1-k];
  end

  int n_chk = 0, n_err = 0;
  int exp_rl[L] = '{1, 2, 7, 4};

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tap(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = W1'(d);
    tick;
    wr_en = 1'b0;
  endtask

  task automatic wait_run;
    int n;
    n = 0;
    while (!(s_ready && coef_ok) && n < 30) begin tick; n++; end
    chk("wait_run", int'(n < 30), 1);
  endtask

  task automatic wait_load;
    int n;
    n = 0;
    while (load_x && n < 30) begin tick; n++; end
    chk("wait_load", int'(n < 30), 1);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; s_valid = 1'b0; s_data = '0;
    tick; tick;
    chk("rst_load_x", load_x, 1);   chk("rst_busy", busy, 0);
    chk("rst_coef_ok", coef_ok, 0); chk("rst_s_ready", s_ready, 0);
    chk("rst_y_valid", y_valid, 0); chk("rst_c_out", c_out, 0);
    chk("rst_x_out", x_out, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_flags", {load_x, s_ready, coef_ok, y_valid, busy}, 5'b10000);
    end

    // Load {1,2,3,4}; a start during LOAD must not restart it.
    for (int k = 0; k < L; k++) wr_tap(k, k + 1);
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < L; i++) begin
      chk("load_x_low", load_x, 0);
      chk("load_c_out", int'($signed(c_out)), i + 1);
      chk("load_busy", busy, 1);
      start = (i == 1);
      tick;
    end
    start = 1'b0;
    chk("run_coef_ok", coef_ok, 1); chk("run_s_ready", s_ready, 1);
    chk("run_load_x", load_x, 1);   chk("run_busy", busy, 0);
    chk("filt_c0", cf[0], 1);       chk("filt_c3", cf[L-1], 4);

    // Impulse: one valid flag, response 4,3,2,1.
    s_valid = 1'b1; s_data = W1'(1); #1;
    chk("imp_x_out", x_out, 1); chk("imp_s_ready", s_ready, 1); chk("imp_y_valid0", y_valid, 0);
    tick;
    s_valid = 1'b0; s_data = '0;
    for (int d = 1; d <= 8; d++) begin
      chk("imp_y_valid", y_valid, int'(d == STAGES));
      if (d >= STAGES) chk("imp_y", acc[0], L - (d - STAGES));
      tick;
    end

    // Signed coefficients with a continuous stream of 255.
    wr_tap(0, -256); wr_tap(1, 255); wr_tap(2, -1); wr_tap(3, 0);
    start = 1'b1; tick; start = 1'b0;
    wait_run;
    chk("sgn_c0", cf[0], -256); chk("sgn_c1", cf[1], 255); chk("sgn_c2", cf[2], -1);
    s_valid = 1'b1; s_data = W1'(255);
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("sgn_ready", s_ready, 1);
      chk("sgn_y_valid", y_valid, int'(k >= STAGES));
      if (k >= STAGES + L - 1) chk("sgn_y", acc[0], -510);
      tick;
    end
    s_valid = 1'b0;

    // Reload with a same-cycle write to tap 2; a write during LOAD is ignored.
    for (int k = 0; k < L; k++) wr_tap(k, k + 1);
    for (int i = 0; i < 8; i++) tick;
    chk("flush_y_valid", y_valid, 0);
    s_valid = 1'b1; s_data = W1'(3); tick;
    s_valid = 1'b0; tick;
    s_valid = 1'b1; s_data = W1'(5); start = 1'b1;
    wr_en = 1'b1; wr_addr = AW'(2); wr_data = W1'(7); #1;
    chk("rl_s_ready", s_ready, 1); chk("rl_y_valid0", y_valid, 0);
    tick;
    s_valid = 1'b0; start = 1'b0; wr_en = 1'b0;
`ifdef FIR_LOADER_DRAIN_EN
    for (int d = 1; d <= STAGES; d++) begin
      chk("drn_s_ready", s_ready, 0); chk("drn_busy", busy, 1);
      chk("drn_load_x", load_x, 1);   chk("drn_x_out", x_out, 0);
      chk("drn_y_valid", y_valid, int'(d == STAGES - 2 || d == STAGES));
      tick;
    end
`endif
    for (int i = 0; i < L; i++) begin
      chk("rl_load_x", load_x, 0);
      chk("rl_c_out", int'($signed(c_out)), exp_rl[i]);
      chk("rl_y_valid", y_valid, 0);
      if (i == 0) begin wr_en = 1'b1; wr_addr = AW'(3); wr_data = W1'(9); end
      else wr_en = 1'b0;
      tick;
    end
    wr_en = 1'b0;
    chk("rl_coef_ok", coef_ok, 1); chk("rl_c2", cf[2], 7);

    // Reset in LOAD cycle 2.
    start = 1'b1; tick; start = 1'b0;
    wait_load;
    tick; tick;
    chk("mid_c_out", int'($signed(c_out)), 7);
    reset = 1'b1; tick;
    chk("mid_rst_load_x", load_x, 1); chk("mid_rst_coef_ok", coef_ok, 0);
    chk("mid_rst_busy", busy, 0);     chk("mid_rst_s_ready", s_ready, 0);
    reset = 1'b0;

    // Bank must come back cleared.
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < L; i++) begin
      chk("clr_load_x", load_x, 0);
      chk("clr_c_out", int'(c_out), 0);
      tick;
    end
    wait_run;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
